// File: rtl/umi_unpack_pipe.sv
// Two-entry elastic stage on a UMI packet channel. Drops opcode-0 packets,
// stores pre-decoded command fields per entry and tracks start-of-message.
module umi_unpack_pipe #(
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          umi_in_valid,
    input  logic [CW-1:0] umi_in_cmd,
    input  logic [AW-1:0] umi_in_dstaddr,
    input  logic [AW-1:0] umi_in_srcaddr,
    input  logic [DW-1:0] umi_in_data,
    output logic          umi_in_ready,
    output logic          umi_out_valid,
    output logic [CW-1:0] umi_out_cmd,
    output logic [AW-1:0] umi_out_dstaddr,
    output logic [AW-1:0] umi_out_srcaddr,
    output logic [DW-1:0] umi_out_data,
    input  logic          umi_out_ready,
    output logic [4:0]    out_opcode,
    output logic [2:0]    out_size,
    output logic [7:0]    out_len,
    output logic [3:0]    out_qos,
    output logic          out_eom,
    output logic [1:0]    out_err,
    output logic [4:0]    out_hostid,
    output logic          out_request,
    output logic          out_response,
    output logic          out_sop,
    output logic [1:0]    out_level,
    output logic [7:0]    drop_count
);

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dstaddr;
        logic [AW-1:0] srcaddr;
        logic [DW-1:0] data;
        logic [4:0]    opcode;
        logic [2:0]    size;
        logic [7:0]    len;
        logic [3:0]    qos;
        logic          eom;
        logic [1:0]    err;
        logic [4:0]    hostid;
        logic          request;
        logic          response;
        logic          sop;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state_r, state_next_s;
    entry_t      slot_r [2];
    entry_t      slot_next_s [2];
    entry_t      head_r, head_next_s, new_entry_s;
    logic        wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
    logic        sop_track_r, ready_r, valid_r;
    logic [7:0]  drop_count_r;
    logic        push_s, store_s, drop_s, pop_s;

    assign push_s  = umi_in_valid & ready_r;
    assign store_s = push_s & (umi_in_cmd[4:0] != 5'd0);
    assign drop_s  = push_s & (umi_in_cmd[4:0] == 5'd0);
    assign pop_s   = valid_r & umi_out_ready;

    // Decode the incoming command once, at write time, into an entry record.
    always_comb begin
        new_entry_s          = '0;
        new_entry_s.cmd      = umi_in_cmd;
        new_entry_s.dstaddr  = umi_in_dstaddr;
        new_entry_s.srcaddr  = umi_in_srcaddr;
        new_entry_s.data     = umi_in_data;
        new_entry_s.opcode   = umi_in_cmd[4:0];
        new_entry_s.size     = umi_in_cmd[7:5];
        new_entry_s.len      = umi_in_cmd[15:8];
        new_entry_s.qos      = umi_in_cmd[19:16];
        new_entry_s.eom      = umi_in_cmd[22];
        new_entry_s.hostid   = umi_in_cmd[31:27];
        new_entry_s.request  = umi_in_cmd[0];
        new_entry_s.response = ~umi_in_cmd[0] & (umi_in_cmd[4:0] != 5'd0);
        new_entry_s.sop      = sop_track_r;
        if (new_entry_s.response) begin
            new_entry_s.err = umi_in_cmd[26:25];
        end else begin
            new_entry_s.err = 2'b00;
        end
    end

    // Occupancy FSM, pointer/slot updates and the next head to present.
    always_comb begin
        state_next_s  = state_r;
        slot_next_s   = slot_r;
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        head_next_s   = '0;
        case (state_r)
            EMPTY: begin
                if (store_s) begin
                    state_next_s = ONE;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            ONE: begin
                if (store_s && !pop_s) begin
                    state_next_s = FULL;
                end else if (!store_s && pop_s) begin
                    state_next_s = EMPTY;
                end else begin
                    state_next_s = ONE;
                end
            end
            FULL: begin
                if (pop_s) begin
                    state_next_s = ONE;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: state_next_s = EMPTY;
        endcase
        if (store_s) begin
            slot_next_s[wr_ptr_r] = new_entry_s;
            wr_ptr_next_s         = ~wr_ptr_r;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_next_s = ~rd_ptr_r;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        if (state_next_s != EMPTY) begin
            head_next_s = slot_next_s[rd_ptr_next_s];
        end else begin
            head_next_s = '0;
        end
    end

    // All state; ready and valid are registered so neither port sees a combinational path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= EMPTY;
            slot_r       <= '{default: '0};
            head_r       <= '0;
            wr_ptr_r     <= 1'b0;
            rd_ptr_r     <= 1'b0;
            sop_track_r  <= 1'b1;
            ready_r      <= 1'b0;
            valid_r      <= 1'b0;
            drop_count_r <= 8'd0;
        end else begin
            state_r  <= state_next_s;
            slot_r   <= slot_next_s;
            head_r   <= head_next_s;
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            ready_r  <= (state_next_s != FULL);
            valid_r  <= (state_next_s != EMPTY);
            if (store_s) begin
                sop_track_r <= umi_in_cmd[22];
            end
            if (drop_s && (drop_count_r != 8'hFF)) begin
                drop_count_r <= drop_count_r + 8'd1;
            end
        end
    end

    assign umi_in_ready    = ready_r;
    assign umi_out_valid   = valid_r;
    assign umi_out_cmd     = head_r.cmd;
    assign umi_out_dstaddr = head_r.dstaddr;
    assign umi_out_srcaddr = head_r.srcaddr;
    assign umi_out_data    = head_r.data;
    assign out_opcode      = head_r.opcode;
    assign out_size        = head_r.size;
    assign out_len         = head_r.len;
    assign out_qos         = head_r.qos;
    assign out_eom         = head_r.eom;
    assign out_err         = head_r.err;
    assign out_hostid      = head_r.hostid;
    assign out_request     = head_r.request;
    assign out_response    = head_r.response;
    assign out_sop         = head_r.sop;
    assign out_level       = state_r;
    assign drop_count      = drop_count_r;

endmodule

// File: tb/tb_umi_unpack_pipe.sv
// Bench for umi_unpack_pipe: directed steps plus random traffic against a
// queue-based reference model of the two-entry stage.
module tb_umi_unpack_pipe;

    logic         clk = 1'b0;
    logic         reset;
    logic         umi_in_valid;
    logic [31:0]  umi_in_cmd;
    logic [63:0]  umi_in_dstaddr, umi_in_srcaddr;
    logic [127:0] umi_in_data;
    logic         umi_in_ready, umi_out_valid, umi_out_ready;
    logic [31:0]  umi_out_cmd;
    logic [63:0]  umi_out_dstaddr, umi_out_srcaddr;
    logic [127:0] umi_out_data;
    logic [4:0]   out_opcode, out_hostid;
    logic [2:0]   out_size;
    logic [7:0]   out_len, drop_count;
    logic [3:0]   out_qos;
    logic         out_eom, out_request, out_response, out_sop;
    logic [1:0]   out_err, out_level;

    umi_unpack_pipe dut (
        .clk(clk), .reset(reset),
        .umi_in_valid(umi_in_valid), .umi_in_cmd(umi_in_cmd),
        .umi_in_dstaddr(umi_in_dstaddr), .umi_in_srcaddr(umi_in_srcaddr),
        .umi_in_data(umi_in_data), .umi_in_ready(umi_in_ready),
        .umi_out_valid(umi_out_valid), .umi_out_cmd(umi_out_cmd),
        .umi_out_dstaddr(umi_out_dstaddr), .umi_out_srcaddr(umi_out_srcaddr),
        .umi_out_data(umi_out_data), .umi_out_ready(umi_out_ready),
        .out_opcode(out_opcode), .out_size(out_size), .out_len(out_len),
        .out_qos(out_qos), .out_eom(out_eom), .out_err(out_err),
        .out_hostid(out_hostid), .out_request(out_request),
        .out_response(out_response), .out_sop(out_sop),
        .out_level(out_level), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  cmd;
        logic [63:0]  dst;
        logic [63:0]  src;
        logic [127:0] data;
        logic         sop;
    } pkt_t;

    pkt_t exp_q[$];
    pkt_t tx_q[$];
    pkt_t cur;
    bit   have_pkt = 1'b0;
    bit   track_m = 1'b1;
    bit   post_reset = 1'b1;
    bit   rec_sop = 1'b0;
    int   drop_m = 0;
    int   max_lvl = 0;
    logic sop_log[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic pkt_t mkp(input logic [31:0] cmd);
        pkt_t p;
        p.cmd  = cmd;
        p.dst  = {$urandom, $urandom};
        p.src  = {$urandom, $urandom};
        p.data = {$urandom, $urandom, $urandom, $urandom};
        p.sop  = 1'b0;
        return p;
    endfunction

    function automatic logic [31:0] rnd_cmd(input bit allow_inv);
        logic [31:0] c;
        c = $urandom;
        if (c[4:0] == 5'd0) c[4:0] = 5'($urandom_range(31, 1));
        if (allow_inv && ($urandom_range(9) == 0)) c[4:0] = 5'd0;
        return c;
    endfunction

    function automatic bit model_ready();
        return !post_reset && (exp_q.size() < 2);
    endfunction

    // Compare every output against the head of the model queue.
    task automatic check_outputs();
        bit          v;
        logic [31:0] c;
        v = (exp_q.size() > 0);
        c = v ? exp_q[0].cmd : 32'd0;
        if (int'(out_level) > max_lvl) max_lvl = int'(out_level);
        cmp("in_ready", umi_in_ready, model_ready());
        cmp("out_valid", umi_out_valid, v);
        cmp("level", out_level, exp_q.size());
        cmp("cmd", umi_out_cmd, c);
        cmp("dstaddr", umi_out_dstaddr, v ? exp_q[0].dst : 64'd0);
        cmp("srcaddr", umi_out_srcaddr, v ? exp_q[0].src : 64'd0);
        cmp("data", umi_out_data, v ? exp_q[0].data : 128'd0);
        cmp("opcode", out_opcode, c[4:0]);
        cmp("size", out_size, c[7:5]);
        cmp("len", out_len, c[15:8]);
        cmp("qos", out_qos, c[19:16]);
        cmp("eom", out_eom, c[22]);
        cmp("err", out_err, (v && !c[0]) ? c[26:25] : 2'd0);
        cmp("hostid", out_hostid, c[31:27]);
        cmp("request", out_request, v && c[0]);
        cmp("response", out_response, v && !c[0]);
        cmp("sop", out_sop, v ? exp_q[0].sop : 1'b0);
        cmp("drop_count", drop_count, drop_m);
    endtask

    task automatic model_update();
        bit push, pop;
        pkt_t p;
        push = umi_in_valid && model_ready();
        pop  = (exp_q.size() > 0) && umi_out_ready;
        if (pop) begin
            if (rec_sop) sop_log.push_back(out_sop);
            void'(exp_q.pop_front());
        end
        if (push) begin
            have_pkt = 1'b0;
            if (cur.cmd[4:0] == 5'd0) begin
                if (drop_m < 255) drop_m++;
            end else begin
                p = cur;
                p.sop = track_m;
                exp_q.push_back(p);
                track_m = cur.cmd[22];
            end
        end
        post_reset = 1'b0;
    endtask

    // One clock: drive at posedge+1, check and advance the model at negedge.
    task automatic cycle(input bit oready, input bit hold);
        if (!have_pkt && tx_q.size() > 0) begin
            cur = tx_q.pop_front();
            have_pkt = 1'b1;
        end else if (have_pkt && $urandom_range(1) == 1) begin
            cur.data = {$urandom, $urandom, $urandom, $urandom};
        end
        umi_in_valid   = have_pkt && !hold;
        umi_in_cmd     = cur.cmd;
        umi_in_dstaddr = cur.dst;
        umi_in_srcaddr = cur.src;
        umi_in_data    = cur.data;
        umi_out_ready  = oready;
        @(negedge clk);
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int max, input int rprob, input int hprob);
        int n = 0;
        while ((have_pkt || tx_q.size() > 0) && n < max) begin
            cycle($urandom_range(99) < rprob, $urandom_range(99) < hprob);
            n++;
        end
        checks++;
        assert (!(have_pkt || tx_q.size() > 0)) else begin
            errors++;
            $error("FAIL run_timeout observed=%0d expected=0", tx_q.size());
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (exp_q.size() > 0 && n < max) begin
            cycle(1'b1, 1'b1);
            n++;
        end
        cycle(1'b1, 1'b1);
        cmp("drain_empty", umi_out_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        umi_in_valid = 1'b0; umi_in_cmd = 32'd0; umi_in_dstaddr = 64'd0;
        umi_in_srcaddr = 64'd0; umi_in_data = 128'd0; umi_out_ready = 1'b0;
        cur = mkp(32'd0);
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_in_ready", umi_in_ready, 1'b0);
        cmp("rst_valid", umi_out_valid, 1'b0);
        cmp("rst_level", out_level, 2'd0);
        cmp("rst_drop", drop_count, 8'd0);
        reset = 1'b0;
        cycle(1'b0, 1'b1);

        // First request
        tx_q.push_back(mkp(32'h0000_0103));
        cycle(1'b0, 1'b0);
        cmp("t1_valid", umi_out_valid, 1'b1);
        cmp("t1_opcode", out_opcode, 5'd3);
        cmp("t1_len", out_len, 8'd1);
        cmp("t1_request", out_request, 1'b1);
        cmp("t1_sop", out_sop, 1'b1);
        cmp("t1_err", out_err, 2'd0);
        cmp("t1_level", out_level, 2'd1);
        cycle(1'b1, 1'b1);

        // Backpressure with three back-to-back packets
        tx_q.push_back(mkp(32'h0040_0001));
        tx_q.push_back(mkp(32'h0040_0205));
        tx_q.push_back(mkp(32'h0040_0307));
        repeat (4) cycle(1'b0, 1'b0);
        cmp("bp_in_ready", umi_in_ready, 1'b0);
        cmp("bp_level", out_level, 2'd2);
        cycle(1'b1, 1'b0);
        cmp("bp_head2", umi_out_cmd, 32'h0040_0205);
        cycle(1'b1, 1'b0);
        cmp("bp_head3", umi_out_cmd, 32'h0040_0307);
        cmp("bp_level3", out_level, 2'd1);
        drain(10);

        // 100-packet streaming at full rate
        for (int i = 0; i < 100; i++) tx_q.push_back(mkp(rnd_cmd(1'b0)));
        max_lvl = 0;
        run(300, 100, 0);
        cmp("stream_max_level", max_lvl, 1);
        drain(10);

        // Invalid opcodes between valid packets
        for (int i = 0; i < 3; i++) begin
            tx_q.push_back(mkp(rnd_cmd(1'b0)));
            tx_q.push_back(mkp(32'h1234_5600));
        end
        tx_q.push_back(mkp(rnd_cmd(1'b0)));
        run(50, 100, 0);
        drain(10);
        cmp("drop3", drop_count, 8'd3);

        for (int i = 0; i < 300; i++) tx_q.push_back(mkp({$urandom_range(32'h7FF_FFFF), 5'd0}));
        run(400, 100, 0);
        drain(10);
        cmp("drop_sat", drop_count, 8'd255);

        // sop sequence for a 3-beat message then a single beat
        tx_q.push_back(mkp(32'h0040_0001));
        run(10, 100, 0);
        drain(10);
        rec_sop = 1'b1;
        tx_q.push_back(mkp(32'h0000_0001));
        tx_q.push_back(mkp(32'h0000_0003));
        tx_q.push_back(mkp(32'h0040_0005));
        tx_q.push_back(mkp(32'h0040_0001));
        run(50, 100, 0);
        drain(10);
        rec_sop = 1'b0;
        cmp("sop_count", sop_log.size(), 4);
        if (sop_log.size() == 4) begin
            cmp("sop0", sop_log[0], 1'b1);
            cmp("sop1", sop_log[1], 1'b0);
            cmp("sop2", sop_log[2], 1'b0);
            cmp("sop3", sop_log[3], 1'b1);
        end

        // Response error field versus request with err bits set
        tx_q.push_back(mkp(32'h0440_0002));
        cycle(1'b0, 1'b0);
        cmp("rsp_err", out_err, 2'd2);
        cmp("rsp_response", out_response, 1'b1);
        cmp("rsp_request", out_request, 1'b0);
        cycle(1'b1, 1'b1);
        tx_q.push_back(mkp(32'h0640_0001));
        cycle(1'b0, 1'b0);
        cmp("req_err", out_err, 2'd0);
        cmp("req_request", out_request, 1'b1);
        cycle(1'b1, 1'b1);

        // Random mixed traffic with gaps and backpressure
        for (int i = 0; i < 400; i++) tx_q.push_back(mkp(rnd_cmd(1'b1)));
        run(4000, 60, 30);
        drain(10);

        // Asynchronous reset while full
        tx_q.push_back(mkp(rnd_cmd(1'b0)));
        tx_q.push_back(mkp(rnd_cmd(1'b0)));
        run(10, 0, 0);
        cmp("pre_rst_level", out_level, 2'd2);
        #2 reset = 1'b1;
        #1;
        cmp("arst_level", out_level, 2'd0);
        cmp("arst_valid", umi_out_valid, 1'b0);
        cmp("arst_drop", drop_count, 8'd0);
        cmp("arst_ready", umi_in_ready, 1'b0);
        cmp("arst_data", umi_out_data, 128'd0);
        exp_q.delete();
        tx_q.delete();
        have_pkt = 1'b0;
        track_m = 1'b1;
        drop_m = 0;
        post_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 50; i++) tx_q.push_back(mkp(rnd_cmd(1'b1)));
        run(500, 70, 20);
        drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
